// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad event path.
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE,
        QUALIFY,
        HELD,
        RELEASE
    } kq_state_t;

    localparam key_code_t KEY_NONE = 4'h0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_sync_fifo.sv
// Small synchronous FIFO for key codes; pointers carry an extra wrap bit.
module keypad_sync_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  key_code_t               data_i,
    output key_code_t               data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             push_eff, pop_eff;
    key_code_t        mem_q [DEPTH];

    // A push into a full FIFO is only accepted when a pop frees the slot the same cycle.
    assign pop_eff  = pop_i && !empty_q;
    assign push_eff = push_i && (!full_q || pop_eff);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_eff) wr_d = wr_q + (PTR_W+1)'(1);
            if (pop_eff)  rd_d = rd_q + (PTR_W+1)'(1);
            cnt_d = CNT_W'(wr_d - rd_d);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= KEY_NONE;
        end else if (push_eff && !clear_i) begin
            mem_q[wr_q[PTR_W-1:0]] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_q[PTR_W-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/keypad_key_queue.sv
// Turns the scanner's level key report into one queued event per qualified press,
// with hold qualification, release re-arm and a small output FIFO.
module keypad_key_queue
    import keypad_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned HOLD_CYCLES    = 1000,
    parameter int unsigned RELEASE_CYCLES = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  key_code_t               key_code,
    input  logic                    key_valid,
    output key_code_t               out_code,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    input  logic                    clear
);

    localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, RELEASE_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    kq_state_t        state_q, state_d;
    key_code_t        cand_q, cand_d, acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             overflow_q, overflow_d;
    logic             push_c, fifo_full, fifo_empty;

    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cand_q     <= KEY_NONE;
            acc_q      <= KEY_NONE;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Press qualification / re-arm state machine.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        push_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    state_d = QUALIFY;
                    cand_d  = key_code;
                    cnt_d   = CNT_ONE;
                end
            end
            QUALIFY: begin
                if (!key_valid) begin
                    state_d = IDLE;
                end else if (key_code != cand_q) begin
                    cand_d = key_code;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == HOLD_LAST) begin
                    push_c  = 1'b1;
                    acc_d   = cand_q;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!key_valid) begin
                    state_d = RELEASE;
                    cnt_d   = CNT_ONE;
                end else if (key_code != acc_q) begin
                    state_d = QUALIFY;
                    cand_d  = key_code;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE: begin
                if (key_valid && key_code == acc_q) begin
                    state_d = HELD;
                end else if (key_valid) begin
                    state_d = QUALIFY;
                    cand_d  = key_code;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == REL_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        // A press dropped on a full FIFO that is not also being drained is remembered.
        if (push_c && fifo_full && !out_ready) overflow_d = 1'b1;

        if (clear) begin
            state_d    = IDLE;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end
    end

    keypad_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear_i (clear),
        .push_i  (push_c),
        .pop_i   (out_ready),
        .data_i  (cand_q),
        .data_o  (out_code),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_key_queue.sv
// Directed and randomized check of keypad_key_queue against a press-level queue model.
module tb_keypad_key_queue;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int REL   = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] key_code;
    logic       key_valid;
    logic [3:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;
    logic       clear;

    int n_vec = 0;
    int n_err = 0;

    // Model: run/low lengths of the input, a lock on the last accepted key, and the queue.
    int         m_run, m_low;
    bit         m_locked, m_ovf;
    logic [3:0] m_prev, m_acc;
    logic [3:0] m_q[$];

    logic [3:0] exp_order [4] = '{4'h1, 4'h2, 4'h3, 4'h4};

    keypad_key_queue #(
        .DEPTH          (DEPTH),
        .HOLD_CYCLES    (HOLD),
        .RELEASE_CYCLES (REL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_code  (key_code),
        .key_valid (key_valid),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .clear     (clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 0;
        m_run    = 0;
        m_low    = 0;
        m_locked = 0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] c, input logic r, input logic clr);
        bit pop, push;
        pop  = r && (m_q.size() != 0);
        push = 0;
        if (clr) begin
            model_reset();
            return;
        end
        if (v) begin
            m_low  = 0;
            m_run  = (m_run > 0 && c == m_prev) ? m_run + 1 : 1;
            m_prev = c;
            if (m_locked && c != m_acc) m_locked = 0;
            if (!m_locked && m_run == HOLD) begin
                push     = 1;
                m_locked = 1;
                m_acc    = c;
            end
        end else begin
            m_run = 0;
            m_low++;
            if (m_locked && m_low == REL) m_locked = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(c);
            else m_ovf = 1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " out_valid"}, 8'(out_valid), 8'(m_q.size() != 0));
        chk({tag, " count"}, 8'(count), 8'(m_q.size()));
        chk({tag, " overflow"}, 8'(overflow), 8'(m_ovf));
        if (m_q.size() != 0) chk({tag, " out_code"}, 8'(out_code), 8'(m_q[0]));
    endtask

    task automatic step(input logic v, input logic [3:0] c, input logic r, input logic clr,
                        input string tag);
        key_valid = v;
        key_code  = c;
        out_ready = r;
        clear     = clr;
        @(posedge clock);
        #1;
        model_step(v, c, r, clr);
        check_model(tag);
    endtask

    task automatic press(input logic [3:0] c, input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, c, 1'b0, 1'b0, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        logic [3:0] rc;
        int         rlen;
        logic       rv;

        reset     = 1'b0;
        key_code  = 4'h0;
        key_valid = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset out_valid", 8'(out_valid), 8'h0);
        chk("reset out_code", 8'(out_code), 8'h0);
        chk("reset count", 8'(count), 8'h0);
        chk("reset overflow", 8'(overflow), 8'h0);
        reset = 1'b1;

        // Single held key: one entry after the 4th sampling edge.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'h5, 1'b0, 1'b0, "s1 hold");
            if (i == 2) chk("s1 valid after 3", 8'(out_valid), 8'h0);
            if (i == 3) chk("s1 valid after 4", 8'(out_valid), 8'h1);
        end
        chk("s1 count", 8'(count), 8'h1);
        chk("s1 head", 8'(out_code), 8'h5);
        step(1'b0, 4'h0, 1'b0, 1'b1, "s1 clear");

        // Candidate change restarts qualification; new key re-arms without release.
        press(4'h5, 2, "s2 five");
        press(4'h7, 4, "s2 seven");
        press(4'h9, 4, "s2 nine");
        chk("s2 count", 8'(count), 8'h2);
        chk("s2 head", 8'(out_code), 8'h7);
        step(1'b0, 4'h0, 1'b0, 1'b1, "s2 clear");

        // Short release is a bounce; full release re-arms the same key.
        press(4'h3, 4, "s3 first");
        idle(2, "s3 bounce low");
        press(4'h3, 3, "s3 bounce high");
        chk("s3 bounce count", 8'(count), 8'h1);
        idle(4, "s3 release");
        press(4'h3, 4, "s3 second");
        chk("s3 count", 8'(count), 8'h2);
        step(1'b0, 4'h0, 1'b0, 1'b1, "s3 clear");

        // Fill, overflow on a fifth press, drain in order; overflow sticky until clear.
        for (int k = 0; k < 4; k++) begin
            press(exp_order[k], 4, "s4 fill");
            idle(1, "s4 gap");
        end
        press(4'hA, 4, "s4 extra");
        chk("s4 count", 8'(count), 8'h4);
        chk("s4 overflow", 8'(overflow), 8'h1);
        for (int k = 0; k < 4; k++) begin
            chk("s4 drain order", 8'(out_code), 8'(exp_order[k]));
            step(1'b0, 4'h0, 1'b1, 1'b0, "s4 drain");
        end
        chk("s4 overflow sticky", 8'(overflow), 8'h1);
        step(1'b0, 4'h0, 1'b0, 1'b1, "s4 clear");
        chk("s4 overflow cleared", 8'(overflow), 8'h0);

        // Push into a full FIFO while it is being drained.
        for (int k = 0; k < 4; k++) begin
            press(exp_order[k], 4, "s5 fill");
            idle(1, "s5 gap");
        end
        press(4'hB, 3, "s5 qualify");
        step(1'b1, 4'hB, 1'b1, 1'b0, "s5 push pop");
        chk("s5 count", 8'(count), 8'h4);
        chk("s5 overflow", 8'(overflow), 8'h0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) chk("s5 last out", 8'(out_code), 8'hB);
            step(1'b0, 4'h0, 1'b1, 1'b0, "s5 drain");
        end
        step(1'b0, 4'h0, 1'b0, 1'b1, "s5 clear");

        // Asynchronous reset mid-qualification discards queue and press in progress.
        press(4'h1, 4, "s6 q1");
        press(4'h2, 4, "s6 q2");
        press(4'h6, 2, "s6 qualify");
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("s6 async out_valid", 8'(out_valid), 8'h0);
        chk("s6 async count", 8'(count), 8'h0);
        chk("s6 async out_code", 8'(out_code), 8'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        press(4'h6, 3, "s6 short hold");
        chk("s6 no entry", 8'(count), 8'h0);
        idle(4, "s6 idle");

        // Randomized runs of keys, gaps, back-pressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            rc   = 4'($urandom_range(0, 3));
            rlen = int'($urandom_range(1, 7));
            rv   = ($urandom_range(0, 4) != 0);
            for (int k = 0; k < rlen; k++)
                step(rv, rc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
